// File: rtl/packet_fifo_sf.sv
// Store-and-forward packet FIFO: words land at a speculative pointer and only become
// readable once their packet commits; errored, oversize or overflowing packets are rewound.
module packet_fifo_sf #(
    parameter int DATA_WIDTH   = 32,
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int DEPTH        = 1024,
    parameter int MAX_PKTS     = 16,
    parameter int DROP_ON_FULL = 0,
    parameter int AW           = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [KEEP_WIDTH-1:0] wr_keep,
    input  logic                  wr_valid,
    input  logic                  wr_sop,
    input  logic                  wr_eop,
    input  logic                  wr_err,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [KEEP_WIDTH-1:0] rd_keep,
    output logic                  rd_valid,
    output logic                  rd_sop,
    output logic                  rd_eop,
    input  logic                  rd_ready,
    output logic [AW:0]           level,
    output logic [7:0]            pkt_count,
    output logic [15:0]           drop_count,
    output logic                  stray_err
);

    localparam int WW = 1 + KEEP_WIDTH + DATA_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PKT  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [7:0]  MAX_W   = 8'(MAX_PKTS);

    // Each stored word is {eop, keep, data}; sop is reconstructed on the read side.
    logic [WW-1:0] mem [DEPTH];

    logic [1:0]  state_reg, state_next;
    logic [AW:0] spec_ptr_reg, spec_next;
    logic [AW:0] cmt_ptr_reg, cmt_next;
    logic [AW:0] rd_ptr_reg;
    logic [AW:0] rd_ptr_out_reg;
    logic [7:0]  pkt_count_reg;
    logic [15:0] drop_count_reg;
    logic        stray_err_reg;

    logic                  out_valid_reg;
    logic                  rd_sop_reg;
    logic                  rd_eop_reg;
    logic [KEEP_WIDTH-1:0] rd_keep_reg;
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic                  sop_next_reg;

    logic [AW:0] used;
    logic        full;
    logic        oversize;
    logic        pkt_full;
    logic        wr_ready_int;
    logic        wr_fire;

    logic        do_start;
    logic        do_cont;
    logic        restart_drop;
    logic        stray_set;
    logic [AW:0] pkt_base;
    logic [AW:0] base_used;
    logic        base_full;
    logic        reject;
    logic        store;
    logic        commit;
    logic        err_drop;
    logic [1:0]  drop_inc;
    logic [16:0] drop_sum;

    logic        rd_fire;
    logic        rd_load;
    logic        consume_eop;

    // A word parked in the output register still occupies its slot until transferred.
    assign used     = spec_ptr_reg - rd_ptr_out_reg;
    assign full     = (used == DEPTH_W);
    assign oversize = full && (cmt_ptr_reg == rd_ptr_out_reg);
    assign pkt_full = (pkt_count_reg == MAX_W);

    generate
        if (DROP_ON_FULL != 0) begin : g_tail_drop
            assign wr_ready_int = 1'b1;
        end else begin : g_backpressure
            assign wr_ready_int = (state_reg == S_DROP)
                               || ((state_reg == S_PKT) && oversize)
                               || (!full && !((state_reg == S_IDLE) && pkt_full));
        end
    endgenerate

    assign wr_fire = wr_valid && wr_ready_int;

    // Classify the accepted word: start of a packet, continuation, or neither.
    always_comb begin
        do_start     = 1'b0;
        do_cont      = 1'b0;
        restart_drop = 1'b0;
        stray_set    = 1'b0;
        pkt_base     = spec_ptr_reg;
        if (wr_fire) begin
            case (state_reg)
                S_IDLE: begin
                    if (wr_sop) begin
                        do_start = 1'b1;
                    end else begin
                        stray_set = 1'b1;
                    end
                end
                S_PKT: begin
                    if (wr_sop) begin
                        do_start     = 1'b1;
                        restart_drop = 1'b1;
                        pkt_base     = cmt_ptr_reg;
                    end else begin
                        do_cont = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign base_used = pkt_base - rd_ptr_out_reg;
    assign base_full = (base_used == DEPTH_W);
    assign reject    = do_start ? (base_full || pkt_full) : (do_cont && full);
    assign store     = (do_start || do_cont) && !reject;
    assign commit    = store && wr_eop && !wr_err;
    assign err_drop  = store && wr_eop && wr_err;
    assign drop_inc  = {1'b0, restart_drop} + {1'b0, reject} + {1'b0, err_drop};
    assign drop_sum  = {1'b0, drop_count_reg} + 17'(drop_inc);

    always_comb begin
        state_next = state_reg;
        spec_next  = spec_ptr_reg;
        cmt_next   = cmt_ptr_reg;
        if (store) begin
            if (wr_eop) begin
                state_next = S_IDLE;
                if (wr_err) begin
                    spec_next = cmt_ptr_reg;
                end else begin
                    spec_next = pkt_base + 1'b1;
                    cmt_next  = pkt_base + 1'b1;
                end
            end else begin
                state_next = S_PKT;
                spec_next  = pkt_base + 1'b1;
            end
        end else if (reject) begin
            spec_next  = cmt_ptr_reg;
            state_next = wr_eop ? S_IDLE : S_DROP;
        end else if (wr_fire && (state_reg == S_DROP) && wr_eop) begin
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            mem[pkt_base[AW-1:0]] <= {wr_eop, wr_keep, wr_data};
        end
    end

    assign rd_fire     = out_valid_reg && rd_ready;
    assign rd_load     = (rd_ptr_reg != cmt_ptr_reg) && (!out_valid_reg || rd_ready);
    assign consume_eop = rd_fire && rd_eop_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            spec_ptr_reg   <= '0;
            cmt_ptr_reg    <= '0;
            pkt_count_reg  <= '0;
            drop_count_reg <= '0;
            stray_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            spec_ptr_reg <= spec_next;
            cmt_ptr_reg  <= cmt_next;
            if (commit && !consume_eop) begin
                pkt_count_reg <= pkt_count_reg + 8'd1;
            end else if (!commit && consume_eop) begin
                pkt_count_reg <= pkt_count_reg - 8'd1;
            end
            drop_count_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (stray_set) begin
                stray_err_reg <= 1'b1;
            end
        end
    end

    // Show-ahead output stage doubles as the registered read port of the storage array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg     <= '0;
            rd_ptr_out_reg <= '0;
            out_valid_reg  <= 1'b0;
            rd_sop_reg     <= 1'b0;
            rd_eop_reg     <= 1'b0;
            rd_keep_reg    <= '0;
            rd_data_reg    <= '0;
            sop_next_reg   <= 1'b1;
        end else begin
            if (rd_fire) begin
                rd_ptr_out_reg <= rd_ptr_out_reg + 1'b1;
            end
            if (rd_load) begin
                {rd_eop_reg, rd_keep_reg, rd_data_reg} <= mem[rd_ptr_reg[AW-1:0]];
                sop_next_reg  <= mem[rd_ptr_reg[AW-1:0]][WW-1];
                rd_sop_reg    <= sop_next_reg;
                out_valid_reg <= 1'b1;
                rd_ptr_reg    <= rd_ptr_reg + 1'b1;
            end else if (rd_fire) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign wr_ready   = wr_ready_int;
    assign rd_valid   = out_valid_reg;
    assign rd_sop     = rd_sop_reg;
    assign rd_eop     = rd_eop_reg;
    assign rd_keep    = rd_keep_reg;
    assign rd_data    = rd_data_reg;
    assign level      = cmt_ptr_reg - rd_ptr_out_reg;
    assign pkt_count  = pkt_count_reg;
    assign drop_count = drop_count_reg;
    assign stray_err  = stray_err_reg;

endmodule

// File: tb/tb_packet_fifo_sf.sv
// Scoreboard bench for packet_fifo_sf: one backpressure instance and one tail-drop
// instance with MAX_PKTS=2, both DEPTH=16.
module tb_packet_fifo_sf;

    localparam int DW    = 32;
    localparam int KW    = 4;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk;
    logic rst_n;

    logic [DW-1:0] wr_data0, wr_data1, rd_data0, rd_data1;
    logic [KW-1:0] wr_keep0, wr_keep1, rd_keep0, rd_keep1;
    logic          wr_valid0, wr_sop0, wr_eop0, wr_err0, wr_ready0;
    logic          wr_valid1, wr_sop1, wr_eop1, wr_err1, wr_ready1;
    logic          rd_valid0, rd_sop0, rd_eop0, rd_ready0;
    logic          rd_valid1, rd_sop1, rd_eop1, rd_ready1;
    logic [AW:0]   level0, level1;
    logic [7:0]    pkt_count0, pkt_count1;
    logic [15:0]   drop_count0, drop_count1;
    logic          stray_err0, stray_err1;

    int tests_run  = 0;
    int fail_count = 0;

    // Expected read words: {sop, eop, keep, data}
    logic [37:0] q0[$];
    logic [37:0] q1[$];
    logic [37:0] exp_w;
    logic [37:0] act_w;
    int          lvl_max;
    bit          track_lvl;

    packet_fifo_sf #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEPTH(DEPTH), .MAX_PKTS(16), .DROP_ON_FULL(0), .AW(AW)
    ) dut0 (
        .clk(clk), .rst_n(rst_n),
        .wr_data(wr_data0), .wr_keep(wr_keep0), .wr_valid(wr_valid0), .wr_sop(wr_sop0),
        .wr_eop(wr_eop0), .wr_err(wr_err0), .wr_ready(wr_ready0),
        .rd_data(rd_data0), .rd_keep(rd_keep0), .rd_valid(rd_valid0), .rd_sop(rd_sop0),
        .rd_eop(rd_eop0), .rd_ready(rd_ready0),
        .level(level0), .pkt_count(pkt_count0), .drop_count(drop_count0), .stray_err(stray_err0)
    );

    packet_fifo_sf #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEPTH(DEPTH), .MAX_PKTS(2), .DROP_ON_FULL(1), .AW(AW)
    ) dut1 (
        .clk(clk), .rst_n(rst_n),
        .wr_data(wr_data1), .wr_keep(wr_keep1), .wr_valid(wr_valid1), .wr_sop(wr_sop1),
        .wr_eop(wr_eop1), .wr_err(wr_err1), .wr_ready(wr_ready1),
        .rd_data(rd_data1), .rd_keep(rd_keep1), .rd_valid(rd_valid1), .rd_sop(rd_sop1),
        .rd_eop(rd_eop1), .rd_ready(rd_ready1),
        .level(level1), .pkt_count(pkt_count1), .drop_count(drop_count1), .stray_err(stray_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("[TB] check %s = %0h ok", name, act);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one word and holds it until accepted (bounded); expected output queued if asked.
    task automatic send(input int which, input logic [31:0] d, input logic [3:0] k,
                        input logic s, input logic e, input logic er, input logic expect_out);
        int  n;
        logic rdy;
        if (which == 0) begin
            wr_data0 = d; wr_keep0 = k; wr_sop0 = s; wr_eop0 = e; wr_err0 = er; wr_valid0 = 1'b1;
            if (expect_out) q0.push_back({s, e, k, d});
        end else begin
            wr_data1 = d; wr_keep1 = k; wr_sop1 = s; wr_eop1 = e; wr_err1 = er; wr_valid1 = 1'b1;
            if (expect_out) q1.push_back({s, e, k, d});
        end
        n = 0;
        @(negedge clk);
        rdy = (which == 0) ? wr_ready0 : wr_ready1;
        while (!rdy && n < 200) begin
            @(negedge clk);
            n++;
            rdy = (which == 0) ? wr_ready0 : wr_ready1;
        end
        tests_run++;
        if (!rdy) begin
            fail_count++;
            $display("[TB] FAIL write_accept dut%0d data=%h: got no wr_ready in 200 cycles, required acceptance", which, d);
        end
        @(posedge clk);
        #1;
        $display("[TB] wr%0d data=%h keep=%h sop=%0b eop=%0b err=%0b", which, d, k, s, e, er);
        if (which == 0) wr_valid0 = 1'b0;
        else            wr_valid1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        wr_data0 = '0; wr_keep0 = '0; wr_valid0 = 1'b0; wr_sop0 = 1'b0; wr_eop0 = 1'b0; wr_err0 = 1'b0;
        wr_data1 = '0; wr_keep1 = '0; wr_valid1 = 1'b0; wr_sop1 = 1'b0; wr_eop1 = 1'b0; wr_err1 = 1'b0;
        rd_ready0 = 1'b1;
        rd_ready1 = 1'b0;
        lvl_max   = 0;
        track_lvl = 1'b0;

        // Output monitor: pops the scoreboard on every transfer of either instance.
        fork
            forever begin
                @(negedge clk);
                if (track_lvl && int'(level0) > lvl_max) lvl_max = int'(level0);
                if (rst_n && rd_valid0 && rd_ready0) begin
                    act_w = {rd_sop0, rd_eop0, rd_keep0, rd_data0};
                    tests_run++;
                    if (q0.size() == 0) begin
                        fail_count++;
                        $display("[TB] FAIL out0_unexpected: got %h, required no output", act_w);
                    end else begin
                        exp_w = q0.pop_front();
                        if (act_w !== exp_w) begin
                            fail_count++;
                            $display("[TB] FAIL out0_word: got %h, expected %h", act_w, exp_w);
                        end else begin
                            $display("[TB] rd0 sop=%0b eop=%0b keep=%h data=%h ok", rd_sop0, rd_eop0, rd_keep0, rd_data0);
                        end
                    end
                end
                if (rst_n && rd_valid1 && rd_ready1) begin
                    act_w = {rd_sop1, rd_eop1, rd_keep1, rd_data1};
                    tests_run++;
                    if (q1.size() == 0) begin
                        fail_count++;
                        $display("[TB] FAIL out1_unexpected: got %h, required no output", act_w);
                    end else begin
                        exp_w = q1.pop_front();
                        if (act_w !== exp_w) begin
                            fail_count++;
                            $display("[TB] FAIL out1_word: got %h, expected %h", act_w, exp_w);
                        end else begin
                            $display("[TB] rd1 sop=%0b eop=%0b keep=%h data=%h ok", rd_sop1, rd_eop1, rd_keep1, rd_data1);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_cycles(1);

        // Reset values
        chk("rst_wr_ready", 32'(wr_ready0), 32'h1);
        chk("rst_rd_valid", 32'(rd_valid0), 32'h0);
        chk("rst_rd_sop_eop", 32'({rd_sop0, rd_eop0}), 32'h0);
        chk("rst_rd_data", rd_data0, 32'h0);
        chk("rst_rd_keep", 32'(rd_keep0), 32'h0);
        chk("rst_level", 32'(level0), 32'h0);
        chk("rst_pkt_count", 32'(pkt_count0), 32'h0);
        chk("rst_drop_count", 32'(drop_count0), 32'h0);
        chk("rst_stray_err", 32'(stray_err0), 32'h0);

        // 3-word good packet, commit latency of one cycle
        send(0, 32'h1100_0000, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
        send(0, 32'h1100_0001, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
        send(0, 32'h1100_0002, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("latency_not_yet_valid", 32'(rd_valid0), 32'h0);
        chk("commit_level", 32'(level0), 32'h3);
        chk("commit_pkt_count", 32'(pkt_count0), 32'h1);
        wait_cycles(1);
        chk("latency_valid", 32'(rd_valid0), 32'h1);
        chk("first_word_sop", 32'(rd_sop0), 32'h1);
        wait_cycles(6);
        chk("t1_pkt_count_drained", 32'(pkt_count0), 32'h0);
        chk("t1_level_drained", 32'(level0), 32'h0);

        // Errored 4-word packet then good 2-word packet
        lvl_max   = 0;
        track_lvl = 1'b1;
        for (int w = 0; w < 4; w++)
            send(0, 32'h2200_0000 + 32'(w), 4'hF, w == 0, w == 3, w == 3, 1'b0);
        send(0, 32'h2300_0000, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
        send(0, 32'h2300_0001, 4'h1, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_cycles(6);
        track_lvl = 1'b0;
        chk("t2_drop_count", 32'(drop_count0), 32'h1);
        chk("t2_level_peak", 32'(lvl_max), 32'h2);

        // Backpressure: 3 packets of 5 words with the reader stalled
        rd_ready0 = 1'b0;
        for (int p = 0; p < 3; p++)
            for (int w = 0; w < 5; w++)
                send(0, 32'h3000_0000 + 32'(p * 16 + w), 4'hF, w == 0, w == 4, 1'b0, 1'b1);
        chk("t3_ready_after_15", 32'(wr_ready0), 32'h1);
        send(0, 32'h3000_0030, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t3_ready_after_16", 32'(wr_ready0), 32'h0);
        wait_cycles(5);
        chk("t3_ready_held_low", 32'(wr_ready0), 32'h0);
        chk("t3_level_full", 32'(level0), 32'hF);
        chk("t3_pkt_count", 32'(pkt_count0), 32'h3);
        chk("t3_no_drop", 32'(drop_count0), 32'h1);
        rd_ready0 = 1'b1;
        send(0, 32'h3000_0031, 4'h1, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_cycles(25);
        chk("t3_level_drained", 32'(level0), 32'h0);
        chk("t3_pkt_count_drained", 32'(pkt_count0), 32'h0);

        // Oversize 20-word packet into an empty FIFO
        for (int w = 0; w < 20; w++)
            send(0, 32'h4000_0000 + 32'(w), 4'hF, w == 0, w == 19, 1'b0, 1'b0);
        wait_cycles(5);
        chk("t4_drop_count", 32'(drop_count0), 32'h2);
        chk("t4_level", 32'(level0), 32'h0);
        chk("t4_no_output", 32'(rd_valid0), 32'h0);
        chk("t4_idle_ready", 32'(wr_ready0), 32'h1);

        // Single-word packet after the oversize drop
        send(0, 32'h4400_00AA, 4'h1, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_cycles(4);
        chk("t4b_pkt_count", 32'(pkt_count0), 32'h0);

        // sop mid-packet rewinds the partial packet
        send(0, 32'h7000_0000, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        send(0, 32'h7000_0001, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        send(0, 32'h7100_0000, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
        send(0, 32'h7100_0001, 4'h7, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_cycles(5);
        chk("t7_restart_drop", 32'(drop_count0), 32'h3);

        // Stray word in IDLE
        chk("stray_before", 32'(stray_err0), 32'h0);
        send(0, 32'h5555_5555, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_cycles(3);
        chk("stray_set", 32'(stray_err0), 32'h1);
        chk("stray_not_stored", 32'(level0), 32'h0);

        // Tail-drop instance: third packet exceeds MAX_PKTS=2
        send(1, 32'h6000_0001, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1);
        send(1, 32'h6000_0002, 4'h3, 1'b1, 1'b1, 1'b0, 1'b1);
        send(1, 32'h6000_0003, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_cycles(2);
        chk("t6_drop_count", 32'(drop_count1), 32'h1);
        chk("t6_pkt_count", 32'(pkt_count1), 32'h2);
        chk("t6_ready_high", 32'(wr_ready1), 32'h1);
        rd_ready1 = 1'b1;
        wait_cycles(6);
        chk("t6_pkt_count_drained", 32'(pkt_count1), 32'h0);

        chk("q0_all_seen", 32'(q0.size()), 32'h0);
        chk("q1_all_seen", 32'(q1.size()), 32'h0);

        // Asynchronous reset mid-packet
        rd_ready0 = 1'b0;
        send(0, 32'h8800_0001, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0);
        send(0, 32'h8900_0000, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_cycles(1);
        chk("pre_reset_valid", 32'(rd_valid0), 32'h1);
        chk("pre_reset_pkt_count", 32'(pkt_count0), 32'h1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_rd_valid", 32'(rd_valid0), 32'h0);
        chk("areset_rd_sop", 32'(rd_sop0), 32'h0);
        chk("areset_rd_eop", 32'(rd_eop0), 32'h0);
        chk("areset_rd_data", rd_data0, 32'h0);
        chk("areset_rd_keep", 32'(rd_keep0), 32'h0);
        chk("areset_level", 32'(level0), 32'h0);
        chk("areset_pkt_count", 32'(pkt_count0), 32'h0);
        chk("areset_drop_count", 32'(drop_count0), 32'h0);
        chk("areset_stray_err", 32'(stray_err0), 32'h0);
        chk("areset_wr_ready", 32'(wr_ready0), 32'h1);
        chk("areset_drop_count1", 32'(drop_count1), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_cycles(2);
        chk("post_reset_rd_valid", 32'(rd_valid0), 32'h0);
        chk("post_reset_level", 32'(level0), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule

// File: doc/packet_fifo_sf.md
# packet_fifo_sf

Parametrised store-and-forward packet FIFO with commit/discard semantics. Sits between the frame assembler and the MAC transmit path. Only complete, error-free packets become visible on the read side; errored, oversize or overflowing packets are rewound and counted. It generalises the byte-wide buffer to multi-byte words with byte-enables, adds a selectable backpressure or tail-drop full policy, and derives read-side packet boundaries from stored per-word flags.

## Interface
- DATA_WIDTH, 32: word width in bits; multiple of 8.
- KEEP_WIDTH, DATA_WIDTH/8: byte-enable width.
- DEPTH, 1024: words of storage; power of 2, ≥16.
- MAX_PKTS, 16: maximum committed packets held at once; ≤255.
- DROP_ON_FULL, 0: 0 = backpressure via wr_ready; 1 = wr_ready held high and the packet is dropped on overflow.
- AW, $clog2(DEPTH): address width.

- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_data  in  DATA_WIDTH  write word.
- wr_keep  in  KEEP_WIDTH  valid bytes; contiguous from bit 0; all-ones except on the eop word.
- wr_valid / wr_sop / wr_eop  in  1  write qualifiers.
- wr_err  in  1  sampled with wr_eop; 1 = discard the packet.
- wr_ready  out  1  write accept.
- rd_data  out  DATA_WIDTH; rd_keep  out  KEEP_WIDTH; rd_valid / rd_sop / rd_eop  out  1.
- rd_ready  in  1  read accept.
- level  out  AW+1  committed words not yet read.
- pkt_count  out  8  committed packets not fully read.
- drop_count  out  16  dropped packets; saturates at 16'hFFFF.
- stray_err  out  1  sticky flag; cleared only by reset.

## Operation
- Pointers: rd_ptr, cmt_ptr and spec_ptr, each AW+1 bits and wrapping naturally. Used = spec_ptr − rd_ptr. Full when used == DEPTH.
- Storage word = {eop, keep, data}. rd_sop is derived: the first word after reset, or the first word after an eop word.
- Write FSM states:
  - IDLE: a word with wr_sop goes to PKT. A word without wr_sop is ignored and sets stray_err.
  - PKT: each accepted word is written at spec_ptr, then spec_ptr++.
  - DROP: words are accepted and discarded until eop.
- eop in PKT:
  - If !wr_err: cmt_ptr ← spec_ptr+1 and pkt_count++.
  - If wr_err: spec_ptr ← cmt_ptr and drop_count++.
  - Either way, return to IDLE.
- wr_sop while in PKT: the partial packet is rewound (spec_ptr ← cmt_ptr) and drop_count++. The new packet starts in that same cycle.
- Full policy:
  - DROP_ON_FULL=0: wr_ready = !full && !(state==IDLE && pkt_count==MAX_PKTS).
  - Oversize case (full while cmt_ptr==rd_ptr, so the packet exceeds DEPTH): rewind, drop_count++, go to DROP. wr_ready stays 1 in DROP.
  - DROP_ON_FULL=1: wr_ready is always 1.
  - A word arriving when full, or an sop arriving when pkt_count==MAX_PKTS: rewind, drop_count++, go to DROP. If that word is also eop, go straight to IDLE.
- wr_eop together with wr_sop in IDLE is a single-word packet; it is committed or discarded as above.
- Read side: a show-ahead output register is loaded from the word at rd_ptr whenever rd_ptr != cmt_ptr and the register is empty or being consumed. rd_ptr++ on load.
- When an eop word is consumed (rd_valid && rd_ready && rd_eop), pkt_count--.
- Simultaneous commit and eop-consume in the same cycle: pkt_count is unchanged.
- level = cmt_ptr − rd_ptr_out, where rd_ptr_out counts words transferred out.

## Timing
- Reset values: wr_ready = 1; rd_valid / rd_sop / rd_eop = 0; rd_data / rd_keep = 0; level = 0; pkt_count = 0; drop_count = 0; stray_err = 0; FSM = IDLE.
- Memory contents are don't-care after reset. Reset mid-packet loses all data with no count update.
- Commit latency: the eop is accepted at edge N, and the packet's first word is on rd_* with rd_valid=1 after edge N+1. This holds when the FIFO was empty.
- Throughput: 1 word/cycle on each side, concurrently.
- rd_valid never deasserts without a transfer. rd_* hold stable while rd_valid && !rd_ready.
- wr_ready is combinational from state and pointers. A write accepted in the cycle a read frees the last slot is not allowed: full is computed from the registered rd_ptr.

## Test plan
- DATA_WIDTH=32, DEPTH=16: write a 3-word packet (keep F,F,3) with wr_err=0 and rd_ready=1 → rd_valid rises 1 cycle after eop. Output is sop on word 0, eop on word 2 with rd_keep=3, pkt_count 1→0, and level returns to 0.
- A 4-word packet with wr_err=1 on eop, followed by a good 2-word packet → only the 2-word packet is read out, drop_count=1, and level peaks at 2.
- DROP_ON_FULL=0, rd_ready=0: write 3 packets of 5 words → wr_ready drops after 15 words plus the first word of packet 4. No drop occurs. Setting rd_ready=1 drains all 15 words in order.
- DROP_ON_FULL=0: a 20-word packet into an empty DEPTH=16 FIFO → all 20 words are accepted, nothing is output, and drop_count=1.
- DROP_ON_FULL=1, MAX_PKTS=2, rd_ready=0: write 3 single-word packets → the third is dropped, drop_count=1, and pkt_count=2.
- A word without sop in IDLE sets stray_err=1 and is not stored. An assertion of rst_n=0 mid-packet returns all outputs to their reset values within the same cycle (asynchronously).
